// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq: two-requester round-robin front end for a 64-bit
// sequential barrel shifter. It processes one distance bit per cycle, so
// every operation takes a fixed 6-cycle latency.
module shift_arbiter_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_value,
    input  logic        req0_dir,
    input  logic [5:0]  req0_dist,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_value,
    input  logic        req1_dir,
    input  logic [5:0]  req1_dist,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        res_id,
    output logic        busy
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DIST_W = 6;
    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIST_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DIST_W-1:0]   dist_q;
    logic                dir_q;
    logic                id_q;
    logic [STEP_W-1:0]   step_q;
    logic                last_q;

    logic                grant_id_c;
    logic                accept_c;
    logic [DATA_W-1:0]   sel_value_c;
    logic                sel_dir_c;
    logic [DIST_W-1:0]   sel_dist_c;
    logic [DIST_W-1:0]   amt_c;
    logic [DATA_W-1:0]   shifted_c;

    // Grant selection: a lone requester wins; otherwise the one not granted last.
    always_comb begin
        grant_id_c = ~last_q;
        if (req0_valid && !req1_valid) begin
            grant_id_c = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_id_c = 1'b1;
        end
        req0_ready  = (state_q == IDLE) && !grant_id_c;
        req1_ready  = (state_q == IDLE) && grant_id_c;
        accept_c    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_value_c = grant_id_c ? req1_value : req0_value;
        sel_dir_c   = grant_id_c ? req1_dir   : req0_dir;
        sel_dist_c  = grant_id_c ? req1_dist  : req0_dist;
    end

    // One barrel stage: shift by 2^step in the captured direction, zero fill.
    always_comb begin
        amt_c     = DIST_W'(1) << step_q;
        shifted_c = dir_q ? (acc_q >> amt_c) : (acc_q << amt_c);
    end

    // FSM, operand capture, accumulator and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dist_q  <= '0;
            dir_q   <= 1'b0;
            id_q    <= 1'b0;
            step_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        acc_q   <= sel_value_c;
                        dist_q  <= sel_dist_c;
                        dir_q   <= sel_dir_c;
                        id_q    <= grant_id_c;
                        last_q  <= grant_id_c;
                        step_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (dist_q[step_q]) begin
                        acc_q <= shifted_c;
                    end
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        step_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Result outputs are pure decodes of registered state.
    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;
    assign res_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Directed bench for shift_arbiter_seq with hand-computed expectations.
`timescale 1ns/1ps
module tb_shift_arbiter_seq;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_dir;
    logic [63:0] req0_value;
    logic [5:0]  req0_dist;
    logic        req1_valid, req1_ready, req1_dir;
    logic [63:0] req1_value;
    logic [5:0]  req1_dist;
    logic        res_valid, res_ready, res_id, busy;
    logic [63:0] res_data;

    int checks = 0;
    int errors = 0;

    shift_arbiter_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_value (req0_value),
        .req0_dir   (req0_dir),
        .req0_dist  (req0_dist),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_value (req1_value),
        .req1_dir   (req1_dir),
        .req1_dist  (req1_dist),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Wait for res_valid, counting edges from the accept edge; expect 6.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd6);
    endtask

    // Single-requester operation; called in IDLE with both valids low.
    task automatic run_op(input string tag, input logic id, input logic [63:0] v,
                          input logic d, input logic [5:0] s, input logic [63:0] exp,
                          input int hold);
        logic [63:0] held;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_value = v; req0_dir = d; req0_dist = s;
        end else begin
            req1_valid = 1'b1; req1_value = v; req1_dir = d; req1_dist = s;
        end
        #1;
        check({tag, "_ready"}, 64'({req1_ready, req0_ready}), id ? 64'd2 : 64'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_value = ~v; req1_value = ~v; req0_dist = ~s; req1_dist = ~s;
        req0_dir = ~d; req1_dir = ~d;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_result(tag);
        check({tag, "_data"}, res_data, exp);
        check({tag, "_id"}, 64'(res_id), 64'(id));
        if (hold > 0) begin
            held = res_data;
            req0_valid = 1'b1; req1_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
                check({tag, "_hold_data"}, res_data, held);
                check({tag, "_hold_id"}, 64'(res_id), 64'(id));
                check({tag, "_hold_ready"}, 64'({req1_ready, req0_ready}), 64'd0);
                check({tag, "_hold_busy"}, 64'(busy), 64'd1);
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_release"}, 64'({busy, res_valid}), 64'd0);
    endtask

    logic        exp_grant;
    logic [63:0] v0, v1, e;
    logic        d0, d1;
    logic [5:0]  s0, s1;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_value = '0; req0_dir = 1'b0; req0_dist = '0;
        req1_valid = 1'b0; req1_value = '0; req1_dir = 1'b0; req1_dist = '0;
        res_ready = 1'b0;
        do_reset();

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_data", res_data, 64'd0);
        check("rst_id", 64'(res_id), 64'd0);
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'd1);

        // res_ready outside DONE is ignored
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("idle_res_ready", 64'({busy, res_valid}), 64'd0);

        run_op("r0_d63", 1'b0, 64'h0000_0000_0000_0001, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 0);
        run_op("r1_d4", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd4, 64'h0FFF_FFFF_FFFF_FFFF, 0);
        run_op("r1_d0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("stall", 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b1, 6'd8, 64'h0012_3456_789A_BCDE, 10);
        run_op("r0_l5", 1'b0, 64'hF000_0000_0000_000F, 1'b0, 6'd5, 64'h0000_0000_0000_01E0, 0);

        // Continuous tie after reset alternates 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req0_value = 64'h1;  req0_dir = 1'b0; req0_dist = 6'd1;
        req1_valid = 1'b1; req1_value = 64'h80; req1_dir = 1'b1; req1_dist = 6'd3;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_grant = 1'(i % 2);
            check("rr_ready", 64'({req1_ready, req0_ready}), exp_grant ? 64'd2 : 64'd1);
            tick();
            wait_result("rr");
            check("rr_id", 64'(res_id), 64'(exp_grant));
            check("rr_data", res_data, exp_grant ? 64'h10 : 64'h2);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("rr_no_same_cycle", 64'(busy), 64'd0);
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Abort on the 3rd SHIFT cycle; req0 granted last, but reset re-prefers 0
        req0_valid = 1'b1; req0_value = 64'hDEAD_BEEF; req0_dir = 1'b0; req0_dist = 6'd3;
        #1;
        check("abort_ready", 64'({req1_ready, req0_ready}), 64'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_data", res_data, 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_result", 64'(res_valid), 64'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("abort_tie", 64'({req1_ready, req0_ready}), 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;

        // Random operands on both requesters under continuous contention
        exp_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v0 = {$urandom, $urandom}; d0 = 1'($urandom); s0 = 6'($urandom);
            v1 = {$urandom, $urandom}; d1 = 1'($urandom); s1 = 6'($urandom);
            req0_valid = 1'b1; req0_value = v0; req0_dir = d0; req0_dist = s0;
            req1_valid = 1'b1; req1_value = v1; req1_dir = d1; req1_dist = s1;
            #1;
            check("rnd_ready", 64'({req1_ready, req0_ready}), exp_grant ? 64'd2 : 64'd1);
            if (exp_grant) e = d1 ? (v1 >> s1) : (v1 << s1);
            else           e = d0 ? (v0 >> s0) : (v0 << s0);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_result("rnd");
            check("rnd_data", res_data, e);
            check("rnd_id", 64'(res_id), 64'(exp_grant));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            tick();
            check("rnd_single", 64'({busy, res_valid}), 64'd0);
            exp_grant = ~exp_grant;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
